// File: rtl/alu_input_loader.sv
// ALU front-end: synchronises and debounces three buttons, and on each clean press
// captures the slide switches into operand A, operand B or the opcode register.
module alu_input_loader #(
  parameter int NB_DATA         = 4,
  parameter int NB_OP           = 6,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_update
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_OP-1:0] OP_RESET = NB_OP'(6'b100000);

  // Bit 0 = operand A, bit 1 = operand B, bit 2 = opcode.
  logic [2:0] btn_raw;
  logic [2:0] sync0_q, sync1_q;
  logic [2:0] deb_q, deb_d;
  logic [2:0] deb_dly_q;
  logic [2:0] press;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               update_q, update_d;

  // Switch bits above the register width are intentionally ignored.
  logic unused_sw;
  assign unused_sw = ^i_sw;

  assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync1_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb_q & ~deb_dly_q;

  always_comb begin
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    op_d     = op_q;
    update_d = |press;
    if (press[0]) dato_a_d = i_sw[NB_DATA-1:0];
    if (press[1]) dato_b_d = i_sw[NB_DATA-1:0];
    if (press[2]) op_d     = i_sw[NB_OP-1:0];
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      dato_a_q  <= '0;
      dato_b_q  <= '0;
      op_q      <= OP_RESET;
      update_q  <= 1'b0;
    end else begin
      sync0_q   <= btn_raw;
      sync1_q   <= sync0_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      dato_a_q  <= dato_a_d;
      dato_b_q  <= dato_b_d;
      op_q      <= op_d;
      update_q  <= update_d;
    end
  end

  assign o_datoA     = dato_a_q;
  assign o_datoB     = dato_b_q;
  assign o_operation = op_q;
  assign o_update    = update_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Bench for alu_input_loader: expected register snapshots are queued when a press is
// driven and compared whenever the DUT pulses o_update.
module tb_alu_input_loader;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op;
  logic [3:0] o_datoA, o_datoB;
  logic [5:0] o_operation;
  logic       o_update;

  always #5 clk = ~clk;

  alu_input_loader #(
    .NB_DATA(4), .NB_OP(6), .NB_SW(8), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_sw(sw),
    .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
    .o_datoA(o_datoA), .o_datoB(o_datoB), .o_operation(o_operation),
    .o_update(o_update)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int upd_cnt  = 0;
  int base;
  logic [13:0] exp_q[$];
  logic [13:0] sb_e;
  logic [3:0]  m_a, m_b;
  logic [5:0]  m_op;
  int          bounce_pat[7] = '{1, 1, 0, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_load(input logic [3:0] a, input logic [3:0] b, input logic [5:0] op);
    m_a = a; m_b = b; m_op = op;
    exp_q.push_back({a, b, op});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller drives just after an edge; the next edge is the first sampling edge.
  task automatic wait_update(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    seen = 1'b0;
    n = 0;
    @(posedge clk);
    repeat (40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (o_update) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    else check(tag, n, exp_lat);
  endtask

  task automatic check_reset_values();
    check("rst_datoA", o_datoA, 4'h0);
    check("rst_datoB", o_datoB, 4'h0);
    check("rst_operation", o_operation, 6'b100000);
    check("rst_update", o_update, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_update) begin
      upd_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_outputs", {18'b0, o_datoA, o_datoB, o_operation}, {18'b0, sb_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sw = 8'h00; btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
    m_a = 4'h0; m_b = 4'h0; m_op = 6'b100000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    tick();
    rst_n = 1'b1;

    // Clean press on A with upper switch bits set.
    tick();
    sw = 8'h0B; btn_a = 1'b1;
    push_load(4'hB, m_b, m_op);
    wait_update("lat_a", D + 2);
    tick();
    btn_a = 1'b0;
    repeat (10) tick();

    // Bouncy B must not load; then a steady press loads once.
    base = upd_cnt;
    foreach (bounce_pat[i]) begin
      tick();
      btn_b = bounce_pat[i][0];
    end
    btn_b = 1'b0;
    repeat (15) tick();
    check("bounce_no_load", upd_cnt - base, 0);
    tick();
    sw = 8'h03; btn_b = 1'b1;
    push_load(m_a, 4'h3, m_op);
    wait_update("lat_b", D + 2);
    tick();
    btn_b = 1'b0;
    repeat (10) tick();
    check("b_single_load", upd_cnt - base, 1);

    // Held opcode button loads once; switch change mid-hold is ignored.
    base = upd_cnt;
    tick();
    sw = 8'h22; btn_op = 1'b1;
    push_load(m_a, m_b, 6'h22);
    repeat (20) tick();
    sw = 8'h27;
    repeat (30) tick();
    btn_op = 1'b0;
    repeat (10) tick();
    check("held_single_load", upd_cnt - base, 1);
    check("op_held_value", o_operation, 6'h22);

    // Simultaneous A and B press: one pulse, both loaded.
    base = upd_cnt;
    tick();
    sw = 8'h07; btn_a = 1'b1; btn_b = 1'b1;
    push_load(4'h7, 4'h7, m_op);
    wait_update("lat_ab", D + 2);
    tick();
    btn_a = 1'b0; btn_b = 1'b0;
    repeat (10) tick();
    check("ab_single_pulse", upd_cnt - base, 1);

    // Reset mid-debounce with the button still held.
    tick();
    sw = 8'h05; btn_a = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    m_a = 4'h0; m_b = 4'h0; m_op = 6'b100000;
    repeat (2) tick();
    @(negedge clk);
    check_reset_values();
    tick();
    push_load(4'h5, 4'h0, 6'b100000);
    rst_n = 1'b1;
    wait_update("lat_after_rst", D + 2);
    tick();
    btn_a = 1'b0;
    repeat (10) tick();

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
